// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - request/response bundle between a core pipeline and the mul/div unit
interface alu_muldiv_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
);
    logic                     start;
    logic                     kill;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic                     busy;
    logic                     done;
    logic [DATA_WIDTH-1:0]    ALUResult;

    modport master (
        output start, kill, Operation, SrcA, SrcB,
        input  busy, done, ALUResult
    );

    modport slave (
        input  start, kill, Operation, SrcA, SrcB,
        output busy, done, ALUResult
    );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative RV32M multiply/divide unit (shift-add / restoring divide)
module alu_muldiv #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_muldiv_if.slave   bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [OPCODE_LENGTH-1:0] OP_MUL    = OPCODE_LENGTH'(0);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULH   = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULHSU = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIV    = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIVU   = OPCODE_LENGTH'(5);
    localparam logic [OPCODE_LENGTH-1:0] OP_REM    = OPCODE_LENGTH'(6);
    localparam logic [OPCODE_LENGTH-1:0] OP_REMU   = OPCODE_LENGTH'(7);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                   state, state_n;
    logic [OPCODE_LENGTH-1:0] op_q;
    logic [W-1:0]             mcand;
    logic [W-1:0]             hi;
    logic [W-1:0]             lo;
    logic                     neg_a, neg_b;
    logic [CW-1:0]            count;
    logic [W-1:0]             result;

    logic                     accept;
    logic                     in_is_div, in_is_rem, in_a_signed, in_b_signed;
    logic                     in_a_neg, in_b_neg, in_fast;
    logic [W-1:0]             in_a_mag, in_b_mag, in_fast_result;

    always_comb begin
        accept      = (state == S_IDLE) && bus.start && !bus.kill;
        in_is_div   = (bus.Operation == OP_DIV) || (bus.Operation == OP_DIVU) ||
                      (bus.Operation == OP_REM) || (bus.Operation == OP_REMU);
        in_is_rem   = (bus.Operation == OP_REM) || (bus.Operation == OP_REMU);
        in_a_signed = (bus.Operation == OP_MULH) || (bus.Operation == OP_MULHSU) ||
                      (bus.Operation == OP_DIV)  || (bus.Operation == OP_REM);
        in_b_signed = (bus.Operation == OP_MULH) || (bus.Operation == OP_DIV) ||
                      (bus.Operation == OP_REM);
        in_a_neg    = in_a_signed && bus.SrcA[W-1];
        in_b_neg    = in_b_signed && bus.SrcB[W-1];
        in_a_mag    = in_a_neg ? (~bus.SrcA + 1'b1) : bus.SrcA;
        in_b_mag    = in_b_neg ? (~bus.SrcB + 1'b1) : bus.SrcB;
        in_fast        = 1'b0;
        in_fast_result = '0;
        if (in_is_div && (bus.SrcB == '0)) begin
            in_fast        = 1'b1;
            in_fast_result = in_is_rem ? bus.SrcA : '1;
        end else if (((bus.Operation == OP_DIV) || (bus.Operation == OP_REM)) &&
                     (bus.SrcA == {1'b1, {(W-1){1'b0}}}) && (bus.SrcB == '1)) begin
            in_fast        = 1'b1;
            in_fast_result = in_is_rem ? '0 : bus.SrcA;
        end
    end

    // One iteration of each algorithm; hi/lo are shared between product and remainder/quotient.
    logic [W:0]     mul_sum, div_shift;
    logic           div_fits;
    logic [W-1:0]   step_hi, step_lo;
    logic           q_is_div, q_is_rem;
    logic [2*W-1:0] prod, prod_signed;
    logic [W-1:0]   quot_signed, rem_signed, final_result;

    always_comb begin
        q_is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU) || (op_q == OP_REM) || (op_q == OP_REMU);
        q_is_rem  = (op_q == OP_REM) || (op_q == OP_REMU);
        mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {W{1'b0}})};
        div_shift = {hi, lo[W-1]};
        div_fits  = div_shift >= {1'b0, mcand};
        if (q_is_div) begin
            step_hi = div_fits ? (div_shift[W-1:0] - mcand) : div_shift[W-1:0];
            step_lo = {lo[W-2:0], div_fits};
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo[W-1:1]};
        end
        prod        = {hi, lo};
        prod_signed = (neg_a ^ neg_b) ? (~prod + 1'b1) : prod;
        quot_signed = (neg_a ^ neg_b) ? (~lo + 1'b1) : lo;
        rem_signed  = neg_a ? (~hi + 1'b1) : hi;
        if (q_is_div)
            final_result = q_is_rem ? rem_signed : quot_signed;
        else if (op_q == OP_MUL)
            final_result = prod_signed[W-1:0];
        else
            final_result = prod_signed[2*W-1:W];
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept) state_n = in_fast ? S_DONE : S_CALC;
            S_CALC: if (bus.kill) state_n = S_IDLE;
                    else if (count == '0) state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= '0;
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            count  <= '0;
            result <= '0;
        end else if (accept) begin
            op_q  <= bus.Operation;
            mcand <= in_b_mag;
            hi    <= '0;
            lo    <= in_a_mag;
            neg_a <= in_a_neg;
            neg_b <= in_b_neg;
            count <= CW'(W);
            if (in_fast) result <= in_fast_result;
        end else if ((state == S_CALC) && !bus.kill) begin
            // count==0 is the terminal cycle: all W steps are already in hi/lo.
            if (count != '0) begin
                hi    <= step_hi;
                lo    <= step_lo;
                count <= count - 1'b1;
            end else begin
                result <= final_result;
            end
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE) && !bus.kill;
    assign bus.ALUResult = result;
endmodule
